// File: rtl/digital_top.sv
// rtl/digital_top.sv - DAG path counter (Kahn sweep, 4-lane ways); ACCUM_SAT_EN selects saturating adds
module digital_top #(
  parameter int PARAM_NODE_IDX_WIDTH  = 10,
  parameter int PARAM_COUNTER_WIDTH   = 5,
  parameter int PARAM_ACCUM_VAL_WIDTH = 24,
  parameter int PARAM_PROD_VAL_WIDTH  = 49,
  parameter int PARAM_FIFO_DEPTH      = 128,
  parameter int NULL_IDX              = 1023,
  parameter int YOU_IDX               = 0,
  parameter int SVR_IDX               = 1,
  parameter int DAC_IDX               = 2,
  parameter int FFT_IDX               = 3,
  parameter int OUT_IDX               = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             part_sel,
  input  logic                             start_run,
  output logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx_reg,
  output logic                             rd_next_node_reg,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
  input  logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
  output logic [PARAM_ACCUM_VAL_WIDTH-1:0] part1_ans,
  output logic [PARAM_PROD_VAL_WIDTH-1:0]  part2_ans,
  output logic                             done_reg
);

  localparam int NW    = PARAM_NODE_IDX_WIDTH;
  localparam int CW    = PARAM_COUNTER_WIDTH;
  localparam int AW    = PARAM_ACCUM_VAL_WIDTH;
  localparam int PW    = PARAM_PROD_VAL_WIDTH;
  localparam int NODES = 1 << NW;
  localparam int FAW   = $clog2(PARAM_FIFO_DEPTH);

  localparam logic [NW-1:0] NULL_N = NW'(NULL_IDX);
  localparam logic [NW-1:0] YOU_N  = NW'(YOU_IDX);
  localparam logic [NW-1:0] SVR_N  = NW'(SVR_IDX);
  localparam logic [NW-1:0] DAC_N  = NW'(DAC_IDX);
  localparam logic [NW-1:0] FFT_N  = NW'(FFT_IDX);
  localparam logic [NW-1:0] OUT_N  = NW'(OUT_IDX);

  typedef enum logic [2:0] {
    ST_IDLE, ST_POP, ST_READ, ST_WAIT, ST_UPDATE, ST_DONE
  } state_t;

  state_t state;

  // Per-node storage; lane index is {fft_seen, dac_seen}
  logic [3:0][PW-1:0] ways_mem [NODES];
  logic [CW-1:0]      rem_mem  [NODES];
  logic [NODES-1:0]   valid;

  // Ready-node FIFO
  logic [NW-1:0] fifo_mem [PARAM_FIFO_DEPTH];
  logic [FAW-1:0] fifo_rd;
  logic [FAW-1:0] fifo_wr;
  logic [FAW:0]   fifo_cnt;
  logic           fifo_empty;
  logic           fifo_full;

  logic          part_q;
  logic [NW-1:0] child_q;
  logic [CW-1:0] child_cnt_q;

  logic               start_ok;
  logic [NW-1:0]      src;
  logic               push_en;
  logic               push_ok;
  logic [NW-1:0]      push_data;
  logic               pop_en;
  logic [3:0][PW-1:0] ways_p;
  logic [3:0][PW-1:0] ways_c;
  logic [3:0][PW-1:0] ways_c_new;
  logic [CW-1:0]      rem_new;
  logic [1:0]         lane_dst;

  function automatic logic [PW-1:0] add_lane(input logic [PW-1:0] a, input logic [PW-1:0] b);
`ifdef ACCUM_SAT_EN
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PW] ? {PW{1'b1}} : s[PW-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [AW-1:0] to_part1(input logic [PW-1:0] v);
`ifdef ACCUM_SAT_EN
    return (|v[PW-1:AW]) ? {AW{1'b1}} : v[AW-1:0];
`else
    return v[AW-1:0];
`endif
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (FAW+1)'(PARAM_FIFO_DEPTH));
  assign start_ok   = start_run && (state == ST_IDLE || state == ST_DONE);
  assign src        = part_sel ? SVR_N : YOU_N;
  assign pop_en     = (state == ST_POP) && !fifo_empty;

  // Lane fold from parent into child and the child's next remaining in-degree
  always_comb begin
    ways_p     = valid[node_idx_reg] ? ways_mem[node_idx_reg] : '0;
    ways_c     = valid[child_q] ? ways_mem[child_q] : '0;
    ways_c_new = ways_c;
    lane_dst   = 2'b00;
    for (int m = 0; m < 4; m++) begin
      lane_dst = m[1:0];
      if (part_q) begin
        if (child_q == DAC_N) lane_dst[0] = 1'b1;
        if (child_q == FFT_N) lane_dst[1] = 1'b1;
      end
      ways_c_new[lane_dst] = add_lane(ways_c_new[lane_dst], ways_p[m]);
    end
    rem_new = valid[child_q] ? (rem_mem[child_q] - CW'(1)) : (child_cnt_q - CW'(1));
  end

  // FIFO push source: the run's source node at start, or a child whose in-degree hit zero
  always_comb begin
    push_en   = 1'b0;
    push_data = child_q;
    if (start_ok) begin
      push_en   = 1'b1;
      push_data = src;
    end else if (state == ST_UPDATE && rem_new == '0) begin
      push_en = 1'b1;
    end
    push_ok = push_en && !fifo_full;
  end

  // Memory writes: node ways, remaining in-degree and FIFO slots (contents need no reset)
  always_ff @(posedge clk) begin
    if (start_ok) begin
      ways_mem[src] <= {{(3*PW){1'b0}}, PW'(1)};
      rem_mem[src]  <= '0;
    end else if (state == ST_UPDATE) begin
      ways_mem[child_q] <= ways_c_new;
      rem_mem[child_q]  <= rem_new;
    end
    if (push_ok) begin
      fifo_mem[fifo_wr] <= push_data;
    end
  end

  // Control FSM, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state            <= ST_IDLE;
      valid            <= '0;
      fifo_rd          <= '0;
      fifo_wr          <= '0;
      fifo_cnt         <= '0;
      part_q           <= 1'b0;
      child_q          <= '0;
      child_cnt_q      <= '0;
      node_idx_reg     <= '0;
      rd_next_node_reg <= 1'b0;
      part1_ans        <= '0;
      part2_ans        <= '0;
      done_reg         <= 1'b0;
    end else begin
      if (push_ok) fifo_wr <= fifo_wr + FAW'(1);
      if (pop_en)  fifo_rd <= fifo_rd + FAW'(1);
      if (push_ok) fifo_cnt <= fifo_cnt + (FAW+1)'(1);
      else if (pop_en) fifo_cnt <= fifo_cnt - (FAW+1)'(1);

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_run) begin
            part_q     <= part_sel;
            done_reg   <= 1'b0;
            part1_ans  <= '0;
            part2_ans  <= '0;
            valid      <= '0;
            valid[src] <= 1'b1;
            state      <= ST_POP;
          end
        end
        ST_POP: begin
          if (fifo_empty) begin
            done_reg <= 1'b1;
            if (valid[OUT_N]) begin
              part1_ans <= part_q ? '0 : to_part1(ways_mem[OUT_N][0]);
              part2_ans <= part_q ? ways_mem[OUT_N][3] : '0;
            end
            state <= ST_DONE;
          end else begin
            node_idx_reg     <= fifo_mem[fifo_rd];
            rd_next_node_reg <= 1'b1;
            state            <= ST_READ;
          end
        end
        ST_READ: begin
          rd_next_node_reg <= 1'b0;
          state            <= ST_WAIT;
        end
        ST_WAIT: begin
          if (next_node_idx == NULL_N) begin
            state <= ST_POP;
          end else begin
            child_q     <= next_node_idx;
            child_cnt_q <= next_node_counter;
            state       <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          valid[child_q]   <= 1'b1;
          rd_next_node_reg <= 1'b1;
          state            <= ST_READ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_top.sv
// tb/tb_digital_top.sv - directed bench for digital_top with an adjacency server model
module tb_digital_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        part_sel;
  logic        start_run;
  logic [9:0]  node_idx_reg;
  logic        rd_next_node_reg;
  logic [9:0]  next_node_idx;
  logic [4:0]  next_node_counter;
  logic [23:0] part1_ans;
  logic [48:0] part2_ans;
  logic        done_reg;

  always #5 clk = ~clk;

  digital_top dut (
    .clk(clk),
    .rst_n(rst_n),
    .part_sel(part_sel),
    .start_run(start_run),
    .node_idx_reg(node_idx_reg),
    .rd_next_node_reg(rd_next_node_reg),
    .next_node_idx(next_node_idx),
    .next_node_counter(next_node_counter),
    .part1_ans(part1_ans),
    .part2_ans(part2_ans),
    .done_reg(done_reg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Adjacency tables owned by the bench
  int e_src[$];
  int e_dst[$];
  int cnt_tbl[1024];
  int rd_ptr[1024];

  int strobe_cnt;
  int pulse_err;
  int stable_err;
  bit prev_rd;
  bit sample_pending;
  logic [9:0] strobe_node;
  int srv_k;
  bit srv_found;

  task automatic clear_graph();
    e_src.delete();
    e_dst.delete();
    for (int i = 0; i < 1024; i++) cnt_tbl[i] = 0;
  endtask

  task automatic add_edge(input int s, input int d);
    e_src.push_back(s);
    e_dst.push_back(d);
  endtask

  // Server: answer each strobe on the falling edge so data is valid through the following cycle
  always @(negedge clk) begin
    if (rst_n) begin
      prev_rd        = 1'b0;
      sample_pending = 1'b0;
    end else begin
      if (sample_pending) begin
        if (node_idx_reg !== strobe_node) stable_err++;
        sample_pending = 1'b0;
      end
      if (rd_next_node_reg) begin
        if (prev_rd) pulse_err++;
        strobe_cnt++;
        strobe_node    = node_idx_reg;
        sample_pending = 1'b1;
        srv_k          = 0;
        srv_found      = 1'b0;
        for (int i = 0; i < e_src.size(); i++) begin
          if (e_src[i] == int'(node_idx_reg)) begin
            if (!srv_found && srv_k == rd_ptr[node_idx_reg]) begin
              next_node_idx     = 10'(e_dst[i]);
              next_node_counter = 5'(cnt_tbl[e_dst[i]]);
              srv_found         = 1'b1;
            end
            srv_k++;
          end
        end
        if (!srv_found) begin
          next_node_idx     = 10'd1023;
          next_node_counter = 5'd0;
        end
        rd_ptr[node_idx_reg]++;
      end
      prev_rd = rd_next_node_reg;
    end
  end

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_reg) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_pulse(input logic psel);
    @(negedge clk);
    part_sel  = psel;
    start_run = 1'b1;
    @(negedge clk);
    start_run = 1'b0;
    part_sel  = 1'b0;
  endtask

  task automatic run(input logic psel, input bit poke, output bit ok);
    for (int i = 0; i < 1024; i++) rd_ptr[i] = 0;
    strobe_cnt = 0;
    pulse_err  = 0;
    stable_err = 0;
    start_pulse(psel);
    if (poke) begin
      repeat (5) @(negedge clk);
      start_pulse(1'b0);
    end
    wait_done(ok);
  endtask

  task automatic load_diamond();
    clear_graph();
    add_edge(0, 5); add_edge(0, 6); add_edge(5, 4); add_edge(6, 4);
    cnt_tbl[5] = 1; cnt_tbl[6] = 1; cnt_tbl[4] = 2;
  endtask

  task automatic load_chain();
    clear_graph();
    add_edge(1, 2); add_edge(1, 3); add_edge(2, 3); add_edge(3, 4);
    cnt_tbl[2] = 1; cnt_tbl[3] = 2; cnt_tbl[4] = 1;
  endtask

  task automatic load_product();
    clear_graph();
    for (int i = 10; i < 13; i++) begin add_edge(1, i); add_edge(i, 3); cnt_tbl[i] = 1; end
    for (int i = 20; i < 22; i++) begin add_edge(3, i); add_edge(i, 2); cnt_tbl[i] = 1; end
    for (int i = 30; i < 34; i++) begin add_edge(2, i); add_edge(i, 4); cnt_tbl[i] = 1; end
    cnt_tbl[3] = 3; cnt_tbl[2] = 2; cnt_tbl[4] = 4;
  endtask

  bit ok;
  int snap;

  initial begin
    rst_n             = 1'b1;
    part_sel          = 1'b0;
    start_run         = 1'b0;
    next_node_idx     = 10'd1023;
    next_node_counter = 5'd0;
    strobe_cnt        = 0;
    pulse_err         = 0;
    stable_err        = 0;
    clear_graph();
    for (int i = 0; i < 1024; i++) rd_ptr[i] = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_done", done_reg, 0);
    check_eq("rst_rd", rd_next_node_reg, 0);
    check_eq("rst_node_idx", node_idx_reg, 0);
    check_eq("rst_part1", part1_ans, 0);
    check_eq("rst_part2", part2_ans, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    load_diamond();
    run(1'b0, 1'b0, ok);
    check_eq("diamond_done", ok, 1);
    check_eq("diamond_part1", part1_ans, 2);
    check_eq("diamond_part2", part2_ans, 0);
    check_eq("diamond_strobes", strobe_cnt, 8);
    check_eq("diamond_pulse", pulse_err, 0);
    check_eq("diamond_stable", stable_err, 0);
    repeat (5) @(negedge clk);
    check_eq("diamond_done_hold", done_reg, 1);
    check_eq("diamond_part1_hold", part1_ans, 2);

    run(1'b1, 1'b0, ok);
    check_eq("unreach_done", ok, 1);
    check_eq("unreach_part1", part1_ans, 0);
    check_eq("unreach_part2", part2_ans, 0);
    check_eq("unreach_strobes", strobe_cnt, 1);

    load_chain();
    run(1'b1, 1'b0, ok);
    check_eq("chain_done", ok, 1);
    check_eq("chain_part2", part2_ans, 1);
    check_eq("chain_part1", part1_ans, 0);
    check_eq("chain_strobes", strobe_cnt, 8);

    load_product();
    run(1'b1, 1'b1, ok);
    check_eq("product_done", ok, 1);
    check_eq("product_part2", part2_ans, 24);
    check_eq("product_part1", part1_ans, 0);
    check_eq("product_strobes", strobe_cnt, 31);
    check_eq("product_pulse", pulse_err, 0);
    check_eq("product_stable", stable_err, 0);

    for (int i = 0; i < 1024; i++) rd_ptr[i] = 0;
    start_pulse(1'b1);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_done", done_reg, 0);
    check_eq("midrst_rd", rd_next_node_reg, 0);
    check_eq("midrst_part2", part2_ans, 0);
    rst_n = 1'b0;
    snap = strobe_cnt;
    repeat (20) @(negedge clk);
    check_eq("midrst_idle_done", done_reg, 0);
    check_eq("midrst_idle_strobes", strobe_cnt, snap);

    load_diamond();
    run(1'b0, 1'b0, ok);
    check_eq("rerun1_done", ok, 1);
    check_eq("rerun1_part1", part1_ans, 2);
    run(1'b0, 1'b0, ok);
    check_eq("rerun2_done", ok, 1);
    check_eq("rerun2_part1", part1_ans, 2);
    check_eq("rerun2_part2", part2_ans, 0);
    check_eq("rerun2_strobes", strobe_cnt, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
